// File: rtl/axrm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : axrm_pkg                                                        |
// | Brief  : Shared types and constants for the iterative 8x8 approximate     |
// |          recursive multiplier (axrm_seq_mul / axrm_mul2x2).               |
// | Contents:                                                                |
// |   axrm_state_e      - controller state encoding (IDLE, RUN, DONE)         |
// |   AXRM_STEPS        - number of 2x2 digit-pair steps per product          |
// |   AXRM_K_W          - width of the step counter                           |
// |   AXRM_DIGIT_W      - digit width in bits                                 |
// |   AXRM_APPROX_3X3   - approximate value used for the 3x3 digit product    |
// |   AXRM_DEFAULT_MASK - default set of approximable steps (low nibbles)     |
// |   axrm_shift()      - bit offset of digit pair (i,j) in the product       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package axrm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } axrm_state_e;

  localparam int          AXRM_STEPS        = 16;
  localparam int          AXRM_K_W          = $clog2(AXRM_STEPS);
  localparam int          AXRM_DIGIT_W      = 2;
  localparam logic [3:0]  AXRM_APPROX_3X3   = 4'd7;
  localparam logic [15:0] AXRM_DEFAULT_MASK = 16'h0033;

  // Digit pair (i,j) carries weight 4^(i+j), i.e. a left shift of 2*(i+j).
  function automatic logic [3:0] axrm_shift(input logic [1:0] i, input logic [1:0] j);
    logic [2:0] s;
    s = {1'b0, i} + {1'b0, j};
    return {s, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axrm_mul2x2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : axrm_mul2x2                                                     |
// | Brief  : Combinational 2x2 digit multiplier. Exact unless 'approx' is     |
// |          set, in which case 3x3 yields 7 instead of 9 (drops a carry).    |
// | Ports  :                                                                 |
// |   a       in  [1:0]  multiplicand digit                                  |
// |   b       in  [1:0]  multiplier digit                                    |
// |   approx  in         select approximate rule for this digit pair         |
// |   product out [3:0]  digit product                                       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module axrm_mul2x2
  import axrm_pkg::*;
(
  input  logic [AXRM_DIGIT_W-1:0] a,
  input  logic [AXRM_DIGIT_W-1:0] b,
  input  logic                    approx,
  output logic [3:0]              product
);

  logic [3:0] w_exact;
  logic       w_both3;

  assign w_exact = {2'b00, a} * {2'b00, b};
  assign w_both3 = (a == 2'b11) && (b == 2'b11);

  // 3x3 is the only digit pair where the approximation differs.
  assign product = (approx && w_both3) ? AXRM_APPROX_3X3 : w_exact;

endmodule
`default_nettype wire

// File: rtl/axrm_seq_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : axrm_seq_mul                                                    |
// | Brief  : Iterative 8x8 recursive multiplier. Walks all sixteen 2x2 digit  |
// |          pairs through one shared axrm_mul2x2 core, one pair per cycle,   |
// |          accumulating into a 16-bit result. Steps flagged in APPROX_MASK  |
// |          use the approximate 3x3 rule when approx_en was set on accept.   |
// | Ports  :                                                                 |
// |   clk        in        rising-edge clock                                 |
// |   rst_n      in        asynchronous active-low reset                     |
// |   in_valid   in        operands valid                                    |
// |   in_ready   out       block can accept operands (IDLE)                  |
// |   a, b       in  [7:0] multiplicand / multiplier                         |
// |   approx_en  in        approximation enable, sampled on accept           |
// |   out_valid  out       result valid (DONE)                               |
// |   out_ready  in        consumer accepts result                           |
// |   result     out [15:0] registered product                              |
// |   busy       out       high in RUN or DONE                               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module axrm_seq_mul #(
  parameter logic [15:0] APPROX_MASK = axrm_pkg::AXRM_DEFAULT_MASK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        approx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);

  import axrm_pkg::*;

  localparam logic [AXRM_K_W-1:0] c_last_k = AXRM_K_W'(AXRM_STEPS - 1);

  axrm_state_e r_state;
  axrm_state_e w_state_nxt;

  logic [7:0]          r_a;
  logic [7:0]          r_b;
  logic                r_approx_en;
  logic [15:0]         r_acc;
  logic [15:0]         r_result;
  logic [AXRM_K_W-1:0] r_k;

  logic                    w_accept;
  logic                    w_run;
  logic                    w_last;
  logic [1:0]              w_i;
  logic [1:0]              w_j;
  logic [AXRM_DIGIT_W-1:0] w_ad;
  logic [AXRM_DIGIT_W-1:0] w_bd;
  logic                    w_approx;
  logic [3:0]              w_p;
  logic [15:0]             w_term;
  logic [15:0]             w_acc_nxt;

  // ---------------------------------------------------------------------
  // Step decode: k[1:0] selects the a digit, k[3:2] the b digit.
  // ---------------------------------------------------------------------
  assign w_i      = r_k[1:0];
  assign w_j      = r_k[3:2];
  assign w_ad     = r_a[{w_i, 1'b0} +: AXRM_DIGIT_W];
  assign w_bd     = r_b[{w_j, 1'b0} +: AXRM_DIGIT_W];
  assign w_approx = r_approx_en & APPROX_MASK[r_k];

  axrm_mul2x2 u_core (
    .a       (w_ad),
    .b       (w_bd),
    .approx  (w_approx),
    .product (w_p)
  );

  // Largest term is 9 << 12, and the exact total tops out at 65025, so the
  // 16-bit accumulator never overflows (approximation only ever subtracts).
  assign w_term    = {12'd0, w_p} << axrm_shift(w_i, w_j);
  assign w_acc_nxt = r_acc + w_term;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = (r_k == c_last_k);

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // New operands are deliberately ignored until the result drains.
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand latch, step counter and accumulator
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_approx_en <= 1'b0;
      r_acc       <= 16'd0;
      r_k         <= '0;
      r_result    <= 16'd0;
    end else if (w_accept) begin
      r_a         <= a;
      r_b         <= b;
      r_approx_en <= approx_en;
      r_acc       <= 16'd0;
      r_k         <= '0;
    end else if (w_run) begin
      r_acc <= w_acc_nxt;
      // Counter wraps back to 0 after the last step, ready for the next op.
      r_k   <= r_k + 1'b1;
      // result only moves on the RUN->DONE edge, so it is stable in DONE.
      if (w_last) begin
        r_result <= w_acc_nxt;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign result    = r_result;

endmodule
`default_nettype wire

// File: doc/axrm_seq_mul.md
# axrm_seq_mul

Iterative 8x8 recursive multiplier controller. It sequences all sixteen 2x2 digit products through one shared 2x2 core, one digit pair per cycle, and accumulates them into a 16-bit result. Digit pairs flagged in `APPROX_MASK` use the approximate 2x2 rule when `approx_en` is set. The block is the area-lean, time-multiplexed counterpart to the fully parallel 8x8 approximate recursive multipliers and uses valid/ready handshakes on both sides.

## Interface
- `APPROX_MASK`, default 16'h0033: bit k = 1 means step k uses the approximate 2x2 rule when `approx_en` is latched high. Step k covers a digit i = k[1:0] and b digit j = k[3:2]. The default marks the low-nibble pairs (i,j) ∈ {0,1}².
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands are valid.
- `in_ready` output 1: block can accept operands.
- `a` input 8: multiplicand.
- `b` input 8: multiplier.
- `approx_en` input 1: enables approximation for the whole operation; sampled on accept.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer accepts `result`.
- `result` output 16: accumulated product, registered.
- `busy` output 1: high while in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `a`, `b` and `approx_en`; clear `acc`; set `k` = 0; go to RUN.
- **RUN:** each cycle:
  - Take digits ad = a_l[2i+1:2i] and bd = b_l[2j+1:2j].
  - p = ad*bd (4 bits).
  - If `approx_en_l` & `APPROX_MASK[k]` & (ad == 3) & (bd == 3), then p = 4'd7 instead of 9. All other digit combinations are exact.
  - acc <= acc + (p << 2(i+j)).
  - k increments. After the step with k = 15, go to DONE and load `result` <= final acc.
- **DONE:**
  - `out_valid` = 1; `result` is held stable.
  - On `out_ready`: go to IDLE.
  - `in_valid` is ignored in DONE.
- **Width:** acc is 16 bits. The maximum exact sum is 65025 and approximate ≤ exact, so overflow cannot occur and no saturation is needed.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded from registered state.
- **Reset:** asynchronous, any state. Effects:
  - state = IDLE and k = 0.
  - acc, `result` and latched operands = 0.
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - An in-flight operation is discarded with no output.

## Timing
- Accept at edge E0. RUN steps k = 0..15 occur at edges E1..E16. State is DONE and `out_valid` = 1 from E16, giving latency 16 cycles from accept to `out_valid`.
- If `out_ready` is high at E16, the handshake completes at E17. `in_ready` rises after E17, and the earliest next accept is E18. Maximum throughput is one product per 18 cycles.
- `result` changes only at the RUN→DONE edge and is constant while `out_valid` is high.
- `approx_en`, `a` and `b` changes after accept have no effect.

## Structure
- Package `axrm_pkg` holds:
  - state enum (IDLE, RUN, DONE);
  - `AXRM_STEPS` = 16;
  - `AXRM_DIGIT_W` = 2;
  - `AXRM_APPROX_3X3` = 4'd7;
  - `AXRM_DEFAULT_MASK` = 16'h0033.
- One sub-module, `axrm_mul2x2`: a combinational 2x2 core with inputs `a[1:0]`, `b[1:0]`, `approx` and output `product[3:0]`. It implements 3x3→7 when `approx`, and is exact otherwise.
- The controller, counter and accumulator live in `axrm_seq_mul`.

## Test plan
- a=255, b=255, `approx_en`=0, `out_ready`=1 → `result`=16'hFE01 (65025). `out_valid` is high exactly 16 cycles after accept, for 1 cycle.
- a=255, b=255, `approx_en`=1, default mask → `result`=16'hFDCF (64975). This is a loss of 2·(1+4+4+16)=50.
- a=3, b=3: with `approx_en`=1 → `result`=7; with `approx_en`=0 → `result`=9. a=170, b=85, `approx_en`=1 → 14450, exact because no 3x3 digit pairs occur.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `result` stable, `in_ready`=0, and a pulsed `in_valid` with new operands is not accepted. Releasing `out_ready` gives the handshake, then `in_ready`=1 on the next cycle.
- Reset mid-RUN (assert `rst_n`=0 at step k=7) → immediately `out_valid`=0, `busy`=0, `in_ready`=1, `result`=0. A following op with a=12, b=10 → `result`=120.
- Back-to-back: `in_valid` held high with `out_ready`=1 for three ops (0×200, 1×1, 128×2) → results 0, 1, 256 in order, with accepts spaced 18 cycles apart.
